// File: rtl/aoc_day1_parser_pkg.sv
// Shared constants, state encoding and byte-class helpers for the day-1 rotation parser.
package aoc_day1_parser_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    typedef enum logic [2:0] {
        S_DIR   = 3'd0,
        S_FIRST = 3'd1,
        S_NUM   = 3'd2,
        S_EMIT  = 3'd3,
        S_SKIP  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == CH_LF) || (c == CH_CR);
    endfunction

endpackage

// File: rtl/aoc_day1_parser_if.sv
// Byte-stream input and decoded-record output handshakes of the parser.
interface aoc_day1_parser_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              dir_r;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_byte, in_valid, in_last, out_ready,
        input  in_ready, out_valid, dir_r, out_data
    );

    modport slave (
        input  in_byte, in_valid, in_last, out_ready,
        output in_ready, out_valid, dir_r, out_data
    );
endinterface

// File: rtl/aoc_dec_acc.sv
// Decimal accumulator: clear / load first digit / acc*10+d with saturation on overflow.
module aoc_dec_acc #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [3:0]        digit_i,
    output logic [DATA_W-1:0] acc_o,
    output logic [DATA_W-1:0] next_c,
    output logic              ovf_c
);
    // Four extra bits hold (2^DATA_W-1)*10+9 without wrapping.
    localparam int unsigned EXT_W = DATA_W + 4;

    logic [DATA_W-1:0] acc_q;
    logic [EXT_W-1:0]  prod_ext;
    logic              prod_ovf;

    assign prod_ext = EXT_W'(acc_q) * EXT_W'(10) + EXT_W'(digit_i);
    assign prod_ovf = |prod_ext[EXT_W-1:DATA_W];
    assign ovf_c    = step_i & prod_ovf;

    always_comb begin
        next_c = acc_q;
        if (clear_i) begin
            next_c = '0;
        end else if (load_i) begin
            next_c = DATA_W'(digit_i);
        end else if (step_i) begin
            next_c = prod_ovf ? '1 : prod_ext[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= next_c;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/aoc_day1_parser.sv
// Parses "L68\nR30\n..." ASCII into (direction, distance) records over ready/valid.
module aoc_day1_parser
    import aoc_day1_parser_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    aoc_day1_parser_if.slave bus,
    output logic [CNT_W-1:0] rec_count,
    output logic             err,
    output logic             done
);
    state_e            state_q, state_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              dir_r_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CNT_W-1:0]  rec_count_q;
    logic              err_q;
    logic              done_q;
    logic              dir_pend_q;
    logic              last_pend_q;

    logic              accept;
    logic              handoff;
    logic              b_digit, b_term, b_lr, b_ws;
    logic              acc_clear, acc_load, acc_step;
    logic              err_set, emit, emit_last, dir_latch;
    logic [DATA_W-1:0] acc_val;
    logic [DATA_W-1:0] acc_next;
    logic              acc_ovf;

    assign accept  = bus.in_valid & in_ready_q;
    assign handoff = out_valid_q & bus.out_ready;
    assign b_digit = is_digit(bus.in_byte);
    assign b_term  = is_term(bus.in_byte);
    assign b_lr    = (bus.in_byte == CH_L) || (bus.in_byte == CH_R);
    assign b_ws    = b_term || (bus.in_byte == CH_SP);

    aoc_dec_acc #(.DATA_W(DATA_W)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear_i (acc_clear),
        .load_i  (acc_load),
        .step_i  (acc_step),
        .digit_i (bus.in_byte[3:0]),
        .acc_o   (acc_val),
        .next_c  (acc_next),
        .ovf_c   (acc_ovf)
    );

    // Line parser: next state plus one-cycle control strobes for the accumulator and flags.
    always_comb begin
        state_d   = state_q;
        acc_clear = 1'b0;
        acc_load  = 1'b0;
        acc_step  = 1'b0;
        err_set   = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        dir_latch = 1'b0;
        unique case (state_q)
            S_DIR: if (accept) begin
                if (b_lr) begin
                    acc_clear = 1'b1;
                    dir_latch = 1'b1;
                    err_set   = bus.in_last;
                    state_d   = bus.in_last ? S_DONE : S_FIRST;
                end else if (b_ws) begin
                    state_d = bus.in_last ? S_DONE : S_DIR;
                end else begin
                    err_set = 1'b1;
                    state_d = bus.in_last ? S_DONE : S_SKIP;
                end
            end
            S_FIRST: if (accept) begin
                if (b_digit) begin
                    acc_load  = 1'b1;
                    emit      = bus.in_last;
                    emit_last = bus.in_last;
                    state_d   = bus.in_last ? S_EMIT : S_NUM;
                end else begin
                    err_set = 1'b1;
                    if (bus.in_last)                 state_d = S_DONE;
                    else if (bus.in_byte == CH_LF)   state_d = S_DIR;
                    else                             state_d = S_SKIP;
                end
            end
            S_NUM: if (accept) begin
                if (b_digit) begin
                    acc_step  = 1'b1;
                    emit      = bus.in_last;
                    emit_last = bus.in_last;
                    state_d   = bus.in_last ? S_EMIT : S_NUM;
                end else if (b_term) begin
                    emit      = 1'b1;
                    emit_last = bus.in_last;
                    state_d   = S_EMIT;
                end else begin
                    err_set = 1'b1;
                    state_d = bus.in_last ? S_DONE : S_SKIP;
                end
            end
            S_EMIT: if (handoff) begin
                state_d = last_pend_q ? S_DONE : S_DIR;
            end
            S_SKIP: if (accept) begin
                if (bus.in_last)               state_d = S_DONE;
                else if (bus.in_byte == CH_LF) state_d = S_DIR;
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_DIR;
        endcase
        err_set = err_set | acc_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_DIR;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            dir_r_q     <= 1'b0;
            out_data_q  <= '0;
            rec_count_q <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            dir_pend_q  <= 1'b0;
            last_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_EMIT);
            err_q      <= err_q | err_set;
            done_q     <= done_q | (state_d == S_DONE);
            if (dir_latch) begin
                dir_pend_q <= (bus.in_byte == CH_R);
            end
            // Record registers only move on emit, so they hold the last record while idle.
            if (emit) begin
                out_valid_q <= 1'b1;
                out_data_q  <= acc_next;
                dir_r_q     <= dir_pend_q;
                last_pend_q <= emit_last;
            end else if (handoff) begin
                out_valid_q <= 1'b0;
                rec_count_q <= rec_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dir_r     = dir_r_q;
    assign bus.out_data  = out_data_q;
    assign rec_count     = rec_count_q;
    assign err           = err_q;
    assign done          = done_q;

    // Debug view of the accumulator; keeps the register observable in simulation.
    logic [DATA_W-1:0] acc_dbg;
    assign acc_dbg = acc_val;
endmodule
